// File: rtl/dma_xfer_ctrl.sv
// Copy-job engine: splits a word-count job into 4KB-safe read/write burst pairs,
// staging each read burst in a local FIFO before replaying it as a write burst.
module dma_xfer_ctrl #(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_BITS   = 16
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_BITS-1:0] xfer_len,
  input  logic                irq_clr,
  output logic                busy,
  output logic                done_irq,
  output logic [3:0]          burst_len,
  output logic                AR_valid,
  output logic [31:0]         read_addr,
  input  logic                read_data_valid,
  input  logic [31:0]         read_data,
  output logic                AW_valid,
  output logic [31:0]         write_addr,
  output logic                W_valid,
  output logic [31:0]         write_data,
  output logic                W_last,
  input  logic                master_W_done,
  input  logic                master_B_done
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_DATA,
    S_WR_RESP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic [BW-1:0]       beats_q, beats_d;
  logic [BW-1:0]       cnt_q, cnt_d;
  logic [31:0]         rd_addr_d, wr_addr_d;
  logic                irq_d;
  logic                push, pop;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_idx_q, rd_idx_d;
  logic [AW-1:0]       wr_idx_q, wr_idx_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic                w_valid_d, w_last_d;

  // Words left before the next 4KB page starting at this byte offset (1..1024).
  function automatic logic [12:0] words_to_4k(input logic [11:0] off);
    return (13'h1000 - {1'b0, off}) >> 2;
  endfunction

  function automatic logic [BW-1:0] clamp_words(input logic [12:0] w);
    return (w >= 13'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(w);
  endfunction

  function automatic logic [BW-1:0] min_b(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
    return (i == AW'(FIFO_DEPTH - 1)) ? '0 : i + AW'(1);
  endfunction

  // Job sequencing and burst sizing.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    cnt_d     = cnt_q;
    rd_addr_d = read_addr;
    wr_addr_d = write_addr;
    irq_d     = irq_clr ? 1'b0 : done_irq;
    push      = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d = src_addr & ~32'h3;
          wr_addr_d = dst_addr & ~32'h3;
          rem_d     = xfer_len;
          irq_d     = 1'b0;
          state_d   = (xfer_len != '0) ? S_RD_REQ : S_DONE;
        end
      end
      S_RD_REQ: begin
        cnt_d   = '0;
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (read_data_valid) begin
          push  = 1'b1;
          cnt_d = cnt_q + BW'(1);
          if (cnt_d == beats_q) state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        cnt_d   = '0;
        state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (W_valid && master_W_done) begin
          pop   = 1'b1;
          cnt_d = cnt_q + BW'(1);
          if (W_last) state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (master_B_done) begin
          rd_addr_d = read_addr + (32'(beats_q) << 2);
          wr_addr_d = write_addr + (32'(beats_q) << 2);
          rem_d     = rem_q - LEN_BITS'(beats_q);
          state_d   = (rem_d == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // RD_REQ lasts one cycle, so this fires exactly once per burst pair.
    if (state_d == S_RD_REQ) begin
      beats_d = min_b(min_b((rem_d >= LEN_BITS'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(rem_d),
                            clamp_words(words_to_4k(rd_addr_d[11:0]))),
                      clamp_words(words_to_4k(wr_addr_d[11:0])));
    end
  end

  // FIFO bookkeeping and the look-ahead for the registered write-beat outputs.
  always_comb begin
    rd_idx_d = pop  ? next_idx(rd_idx_q) : rd_idx_q;
    wr_idx_d = push ? next_idx(wr_idx_q) : wr_idx_q;
    fcnt_d   = fcnt_q;
    if (push)     fcnt_d = fcnt_q + CW'(1);
    else if (pop) fcnt_d = fcnt_q - CW'(1);
    w_valid_d = (state_d == S_WR_DATA) && (fcnt_d != '0);
    w_last_d  = w_valid_d && (cnt_d == beats_q - BW'(1));
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      beats_q    <= '0;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      fcnt_q     <= '0;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
      burst_len  <= '0;
      AR_valid   <= 1'b0;
      read_addr  <= '0;
      AW_valid   <= 1'b0;
      write_addr <= '0;
      W_valid    <= 1'b0;
      write_data <= '0;
      W_last     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      fcnt_q     <= fcnt_d;
      busy       <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_irq   <= irq_d;
      AR_valid   <= (state_d == S_RD_REQ);
      AW_valid   <= (state_d == S_WR_REQ);
      read_addr  <= rd_addr_d;
      write_addr <= wr_addr_d;
      W_valid    <= w_valid_d;
      W_last     <= w_last_d;
      if (state_d == S_RD_REQ) burst_len <= 4'(beats_d - BW'(1));
      if (w_valid_d)           write_data <= mem[rd_idx_d];
    end
  end

  // Data storage needs no reset; occupancy is tracked by fcnt_q.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_idx_q] <= read_data;
  end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Scoreboard bench for dma_xfer_ctrl: directed jobs push expected bursts/beats,
// bus responders model the master, and a monitor checks every presented output.
module tb_dma_xfer_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] xfer_len;
  logic        irq_clr;
  logic        busy, done_irq;
  logic [3:0]  burst_len;
  logic        AR_valid, AW_valid;
  logic [31:0] read_addr, write_addr;
  logic        read_data_valid;
  logic [31:0] read_data;
  logic        W_valid, W_last;
  logic [31:0] write_data;
  logic        master_W_done, master_B_done;

  dma_xfer_ctrl #(.MAX_BURST(16), .FIFO_DEPTH(16), .LEN_BITS(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .xfer_len(xfer_len), .irq_clr(irq_clr), .busy(busy),
    .done_irq(done_irq), .burst_len(burst_len), .AR_valid(AR_valid),
    .read_addr(read_addr), .read_data_valid(read_data_valid), .read_data(read_data),
    .AW_valid(AW_valid), .write_addr(write_addr), .W_valid(W_valid),
    .write_data(write_data), .W_last(W_last), .master_W_done(master_W_done),
    .master_B_done(master_B_done)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] addr; logic [3:0] len; } req_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;

  req_t  exp_ar[$];
  req_t  exp_aw[$];
  beat_t exp_w[$];

  int checks = 0;
  int errors = 0;

  int rd_limit  = 1 << 30;
  int rd_total  = 0;
  bit rd_gap    = 0;
  int stall_at  = -1;
  int stall_len = 0;
  int w_total   = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_burst(input logic [31:0] ra, input logic [31:0] wa, input int beats);
    req_t  r;
    beat_t b;
    r.addr = ra; r.len = 4'(beats - 1); exp_ar.push_back(r);
    r.addr = wa; exp_aw.push_back(r);
    for (int i = 0; i < beats; i++) begin
      b.data = pat(ra + 32'(i * 4));
      b.last = (i == beats - 1);
      exp_w.push_back(b);
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(posedge ACLK); #1;
    src_addr = s; dst_addr = d; xfer_len = l; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done_irq && n < 1000) begin
      @(negedge ACLK);
      n++;
    end
    if (!done_irq) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got done_irq=0, expected 1 within 1000 cycles", nm);
    end
  endtask

  task automatic clear_irq(input string nm);
    @(posedge ACLK); #1 irq_clr = 1'b1;
    @(negedge ACLK); chk({nm, "_irq_before_clr"}, 32'(done_irq), 1);
    @(posedge ACLK); #1 irq_clr = 1'b0;
    @(negedge ACLK); chk({nm, "_irq_after_clr"}, 32'(done_irq), 0);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_busy"},       32'(busy), 0);
    chk({nm, "_done_irq"},   32'(done_irq), 0);
    chk({nm, "_burst_len"},  32'(burst_len), 0);
    chk({nm, "_AR_valid"},   32'(AR_valid), 0);
    chk({nm, "_read_addr"},  read_addr, 0);
    chk({nm, "_AW_valid"},   32'(AW_valid), 0);
    chk({nm, "_write_addr"}, write_addr, 0);
    chk({nm, "_W_valid"},    32'(W_valid), 0);
    chk({nm, "_write_data"}, write_data, 0);
    chk({nm, "_W_last"},     32'(W_last), 0);
  endtask

  // Read side of the master: returns burst_len+1 beats after each AR pulse.
  initial begin
    int pending;
    int idx;
    logic [31:0] base;
    bit tog;
    pending = 0; idx = 0; base = '0; tog = 0;
    read_data_valid = 1'b0; read_data = '0;
    forever begin
      @(posedge ACLK); #1;
      tog = ~tog;
      if (!ARESETn) begin
        pending = 0;
        read_data_valid = 1'b0;
      end else begin
        if (pending > 0 && rd_total < rd_limit && !(rd_gap && tog)) begin
          read_data_valid = 1'b1;
          read_data = pat(base + 32'(idx * 4));
          idx++; pending--; rd_total++;
        end else begin
          read_data_valid = 1'b0;
        end
        if (AR_valid) begin
          pending = int'(burst_len) + 1;
          base = read_addr;
          idx = 0;
        end
      end
    end
  end

  // Write side of the master: accepts beats (with an optional stall) and answers B.
  initial begin
    bit bpend;
    int stalled;
    bpend = 0; stalled = 0;
    master_W_done = 1'b0; master_B_done = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        master_W_done = 1'b0; master_B_done = 1'b0; bpend = 0; stalled = 0;
      end else begin
        master_B_done = bpend;
        bpend = 0;
        if (W_valid) begin
          if (w_total == stall_at && stalled < stall_len) begin
            master_W_done = 1'b0;
            stalled++;
          end else begin
            master_W_done = 1'b1;
            w_total++;
            stalled = 0;
            bpend = W_last;
          end
        end else begin
          master_W_done = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every request, every presented write beat, and job completion.
  initial begin
    bit ar_p, aw_p, stall_p, done_p;
    req_t r;
    beat_t b;
    ar_p = 0; aw_p = 0; stall_p = 0; done_p = 0;
    forever begin
      @(negedge ACLK);
      if (ARESETn) begin
        if (AR_valid) begin
          chk("ar_single_cycle", 32'(ar_p), 0);
          if (exp_ar.size() == 0) begin
            checks++; errors++;
            $display("FAIL ar_unexpected: got request at 0x%08h, expected none", read_addr);
          end else begin
            r = exp_ar.pop_front();
            chk("ar_addr", read_addr, r.addr);
            chk("ar_len", 32'(burst_len), 32'(r.len));
          end
        end
        if (AW_valid) begin
          chk("aw_single_cycle", 32'(aw_p), 0);
          if (exp_aw.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected: got request at 0x%08h, expected none", write_addr);
          end else begin
            r = exp_aw.pop_front();
            chk("aw_addr", write_addr, r.addr);
            chk("aw_len", 32'(burst_len), 32'(r.len));
          end
        end
        if (stall_p) chk("w_valid_held", 32'(W_valid), 1);
        if (W_valid) begin
          if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got beat 0x%08h, expected none", write_data);
          end else begin
            b = exp_w[0];
            chk("w_data", write_data, b.data);
            chk("w_last", 32'(W_last), 32'(b.last));
            if (master_W_done) void'(exp_w.pop_front());
          end
        end
        if (done_irq && !done_p) begin
          chk("done_busy", 32'(busy), 0);
          chk("done_ar_left", 32'(exp_ar.size()), 0);
          chk("done_aw_left", 32'(exp_aw.size()), 0);
          chk("done_w_left", 32'(exp_w.size()), 0);
        end
      end
      ar_p = AR_valid; aw_p = AW_valid;
      stall_p = W_valid && !master_W_done;
      done_p = done_irq;
    end
  end

  initial begin
    int n;
    req_t r;
    ARESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0;
    xfer_len = '0; irq_clr = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_idle_outputs("rst");
    @(posedge ACLK); #1 ARESETn = 1'b1;

    // Single short job.
    exp_burst(32'h0000_1000, 32'h0000_2000, 4);
    pulse_start(32'h0000_1000, 32'h0000_2000, 16'd4);
    @(negedge ACLK); chk("t1_busy", 32'(busy), 1);
    wait_done("t1");
    clear_irq("t1");

    // 16 + 4 split, with gaps in the read stream.
    rd_gap = 1;
    exp_burst(32'h0000_5000, 32'h0000_6000, 16);
    exp_burst(32'h0000_5040, 32'h0000_6040, 4);
    pulse_start(32'h0000_5000, 32'h0000_6000, 16'd20);
    wait_done("t2");
    rd_gap = 0;

    // Source 4KB split; low address bits ignored; start clears the pending irq.
    exp_burst(32'h0000_0FF8, 32'h0000_3000, 2);
    exp_burst(32'h0000_1000, 32'h0000_3008, 6);
    pulse_start(32'h0000_0FFB, 32'h0000_3003, 16'd8);
    @(negedge ACLK); chk("t3_start_clears_irq", 32'(done_irq), 0);
    wait_done("t3");
    clear_irq("t3");

    // Destination 4KB split.
    exp_burst(32'h0000_0100, 32'h0000_7FF0, 4);
    exp_burst(32'h0000_0110, 32'h0000_8000, 2);
    pulse_start(32'h0000_0100, 32'h0000_7FF0, 16'd6);
    wait_done("t4");
    clear_irq("t4");

    // Address wrap past 2^32.
    exp_burst(32'hFFFF_FFF8, 32'h0000_0100, 2);
    exp_burst(32'h0000_0000, 32'h0000_0108, 2);
    pulse_start(32'hFFFF_FFF8, 32'h0000_0100, 16'd4);
    wait_done("t5");
    clear_irq("t5");

    // Write stall mid-burst plus a start pulse while busy.
    stall_at = w_total + 3;
    stall_len = 5;
    exp_burst(32'h0000_0400, 32'h0000_0800, 8);
    pulse_start(32'h0000_0400, 32'h0000_0800, 16'd8);
    repeat (4) @(posedge ACLK);
    pulse_start(32'hAAAA_0000, 32'hBBBB_0000, 16'd3);
    wait_done("t6");
    repeat (6) @(negedge ACLK);
    chk("t6_no_retrigger_busy", 32'(busy), 0);
    chk("t6_stall_applied", 32'(w_total - stall_at), 5);
    clear_irq("t6");

    // Zero-length job.
    pulse_start(32'h0000_0010, 32'h0000_0020, 16'd0);
    @(negedge ACLK); chk("t7_busy_in_done", 32'(busy), 0);
    @(negedge ACLK); chk("t7_done_irq", 32'(done_irq), 1);
    chk("t7_busy", 32'(busy), 0);
    repeat (3) @(negedge ACLK);
    clear_irq("t7");

    // Reset after 3 of 8 read beats.
    r.addr = 32'h0000_2000; r.len = 4'd7;
    exp_ar.push_back(r);
    rd_limit = rd_total + 3;
    pulse_start(32'h0000_2000, 32'h0000_3000, 16'd8);
    n = 0;
    while (rd_total < rd_limit && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    chk("t8_beats_delivered", 32'(rd_limit - rd_total), 0);
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(negedge ACLK);
    check_idle_outputs("t8_midrst");
    chk("t8_ar_seen", 32'(exp_ar.size()), 0);
    @(posedge ACLK);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    rd_limit = 1 << 30;

    // Full job after the abandoned one.
    exp_burst(32'h0000_2000, 32'h0000_3000, 8);
    pulse_start(32'h0000_2000, 32'h0000_3000, 16'd8);
    wait_done("t9");
    clear_irq("t9");

    repeat (3) @(negedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_xfer_ctrl.md
Name: dma_xfer_ctrl

Overview:
Transfer engine that sits directly upstream of the DMA AXI master FSM. It takes a software-programmed copy job (source, destination, word count) and splits it into read-burst / write-burst pairs. It requests each read burst, buffers the returned beats in a local FIFO, then replays them as a write burst and waits for the write response. It raises a done interrupt when the whole job completes.

Parameters:
MAX_BURST, 16, maximum beats per burst (1..16); burst_len = beats-1
FIFO_DEPTH, 16, data buffer depth in words; must be >= MAX_BURST
LEN_BITS, 16, width of job word count

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle job start pulse
src_addr  in  32  job source byte address; bits[1:0] ignored (treated 0)
dst_addr  in  32  job destination byte address; bits[1:0] ignored
xfer_len  in  LEN_BITS  job length in 32-bit words
irq_clr  in  1  clears done_irq
busy  out  1  job in progress
done_irq  out  1  level interrupt, job complete
burst_len  out  4  beats-1 of current burst, to master FSM
AR_valid  out  1  read-burst request pulse
read_addr  out  32  current read burst address
read_data_valid  in  1  accepted read beat
read_data  in  32  read beat data
AW_valid  out  1  write-burst request pulse
write_addr  out  32  current write burst address
W_valid  out  1  write beat valid
write_data  out  32  write beat data (FIFO head)
W_last  out  1  final beat of current write burst
master_W_done  in  1  write beat accepted
master_B_done  in  1  write response received

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO empty; counters 0.
- start sampled only in IDLE. Job registers latch src/dst (bits[1:0] forced 0) and xfer_len. start while busy is ignored. start also clears done_irq.
- xfer_len==0: go straight to DONE. No bus traffic.
- Beats per burst = min(remaining, MAX_BURST, words to next 4KB boundary of rd ptr, words to next 4KB boundary of wr ptr). Words to a boundary = (0x1000 - addr[11:0])>>2. The value is computed in RD_REQ and held for the whole burst pair.
- States:
  - IDLE: start -> RD_REQ (len!=0) or DONE.
  - RD_REQ: AR_valid=1 for exactly one cycle. burst_len and read_addr are valid this cycle -> RD_DATA.
  - RD_DATA: each read_data_valid pushes read_data into the FIFO and increments the beat counter. After the beats-th push -> WR_REQ.
  - WR_REQ: AW_valid=1 for exactly one cycle -> WR_DATA.
  - WR_DATA: W_valid = FIFO not empty. write_data = FIFO head. W_last = (beat index == beats-1) && W_valid. master_W_done pops the FIFO. Pop with W_last -> WR_RESP.
  - WR_RESP: on master_B_done, rd/wr ptrs += beats*4 and remaining -= beats. Then remaining==0 -> DONE, else -> RD_REQ.
  - DONE: done_irq set, busy cleared -> IDLE in the next cycle.
- busy=1 in every state except IDLE/DONE.
- read_addr, write_addr and burst_len are held stable from RD_REQ until WR_RESP exits, because the master passes them through combinationally.
- write_data and W_last are held stable while W_valid=1 and no master_W_done.
- AR_valid and AW_valid are never held high; a level would retrigger the master FSM.
- done_irq: set on DONE entry, cleared by irq_clr or start. If irq_clr and DONE entry occur in the same cycle, set wins.
- A FIFO overflow cannot occur by construction: beats <= MAX_BURST <= FIFO_DEPTH. read_data_valid outside RD_DATA is ignored.
- Reset asserted mid-job: immediate return to reset values and the job is abandoned. Bus-side recovery is the master's reset.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- src=0x0000_1000, dst=0x0000_2000, len=4: one AR (burst_len=3, addr 0x1000), 4 read beats D0..D3. Then one AW (burst_len=3, addr 0x2000) and writes D0..D3 in order with W_last on D3. After B, done_irq=1 and busy=0.
- len=20: bursts of 16 then 4. Second AR addr = src+0x40, second AW addr = dst+0x40. burst_len 15 then 3.
- src=0x0000_0FF8, dst=0x0000_3000, len=8: 4KB split gives bursts of 2 (addr 0xFF8) and 6 (addr 0x1000). Write addrs 0x3000 and 0x3008.
- Write stall: hold master_W_done=0 for 5 cycles mid-burst. W_valid stays 1 and write_data/W_last stay unchanged. No beat is skipped or duplicated.
- len=0 start: no AR_valid/AW_valid, done_irq=1 two cycles after start. start pulse while busy: job registers unchanged. irq_clr deasserts done_irq next cycle.
- Reset pulse in RD_DATA after 3 of 8 beats: all outputs 0, busy=0, FIFO empty. A subsequent start runs a full correct job.
